// File: rtl/dmem_seq.sv
// Load/store sequencer between the execute stage and a handshaked data-memory port.
// Takes one access at a time, issues a word-aligned request with byte mask and
// lane-replicated store data, stalls the hart until completion, and returns
// extended load data with an error code.
module dmem_seq #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_err,
    output logic        o_req,
    output logic [31:0] o_req_addr,
    output logic        o_req_wen,
    output logic [3:0]  o_req_mask,
    output logic [31:0] o_req_wdata,
    input  logic        i_req_ready,
    input  logic        i_res_valid,
    input  logic [31:0] i_res_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_ILL   = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t         state_reg;
    logic [2:0]     funct3_reg;
    logic [1:0]     lane_reg;
    logic [CW-1:0]  cnt_reg;

    logic           start;
    logic           bad_op;
    logic           misaligned;
    logic [3:0]     mask_in;
    logic [31:0]    wdata_in;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [31:0]    load_ext;

    assign start = i_valid & (i_mem_read | i_mem_write);

    // Stall is combinational so the hart freezes in the same cycle the op is accepted;
    // it drops in DONE so the hart advances on the completion pulse.
    assign o_stall = ~i_rst & (((state_reg == S_IDLE) & start) |
                               (state_reg == S_REQ) | (state_reg == S_WAIT));

    // Decode the incoming access: legality, alignment, byte enables and store lanes.
    always_comb begin
        bad_op     = 1'b0;
        misaligned = 1'b0;
        mask_in    = 4'b0000;
        wdata_in   = i_wdata;
        if (i_mem_read & i_mem_write) begin
            bad_op = 1'b1;
        end
        if (!(i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
            bad_op = 1'b1;
        end
        if (i_mem_write & i_funct3[2]) begin
            bad_op = 1'b1;
        end
        case (i_funct3[1:0])
            2'b00: begin
                mask_in  = 4'b0001 << i_addr[1:0];
                wdata_in = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                mask_in    = i_addr[1] ? 4'b1100 : 4'b0011;
                wdata_in   = {2{i_wdata[15:0]}};
                misaligned = i_addr[0];
            end
            2'b10: begin
                mask_in    = 4'b1111;
                wdata_in   = i_wdata;
                misaligned = |i_addr[1:0];
            end
            default: begin
                mask_in  = 4'b0000;
                wdata_in = i_wdata;
            end
        endcase
    end

    // Pick the addressed lane from the response word and sign/zero-extend it.
    always_comb begin
        case (lane_reg)
            2'b00:   byte_sel = i_res_rdata[7:0];
            2'b01:   byte_sel = i_res_rdata[15:8];
            2'b10:   byte_sel = i_res_rdata[23:16];
            default: byte_sel = i_res_rdata[31:24];
        endcase
        half_sel = lane_reg[1] ? i_res_rdata[31:16] : i_res_rdata[15:0];
        case (funct3_reg)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_ext = i_res_rdata;
            3'b100:  load_ext = {24'h000000, byte_sel};
            3'b101:  load_ext = {16'h0000, half_sel};
            default: load_ext = 32'h0000_0000;
        endcase
    end

    // Sequencer: accept, request until handshake, wait for the read response, complete.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= S_IDLE;
            funct3_reg  <= 3'b000;
            lane_reg    <= 2'b00;
            cnt_reg     <= '0;
            o_done      <= 1'b0;
            o_rdata     <= 32'h0000_0000;
            o_err       <= ERR_OK;
            o_req       <= 1'b0;
            o_req_addr  <= 32'h0000_0000;
            o_req_wen   <= 1'b0;
            o_req_mask  <= 4'b0000;
            o_req_wdata <= 32'h0000_0000;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    o_done <= 1'b0;
                    o_err  <= ERR_OK;
                    if (start) begin
                        funct3_reg  <= i_funct3;
                        lane_reg    <= i_addr[1:0];
                        o_req_addr  <= {i_addr[31:2], 2'b00};
                        o_req_wen   <= i_mem_write;
                        o_req_mask  <= mask_in;
                        o_req_wdata <= wdata_in;
                        if (bad_op) begin
                            state_reg <= S_DONE;
                            o_done    <= 1'b1;
                            o_err     <= ERR_ILL;
                            o_rdata   <= 32'h0000_0000;
                        end else if (misaligned) begin
                            state_reg <= S_DONE;
                            o_done    <= 1'b1;
                            o_err     <= ERR_ALIGN;
                            o_rdata   <= 32'h0000_0000;
                        end else begin
                            state_reg <= S_REQ;
                            o_req     <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // Request fields stay frozen until the memory takes them; no timeout here.
                    if (i_req_ready) begin
                        o_req <= 1'b0;
                        if (o_req_wen) begin
                            state_reg <= S_DONE;
                            o_done    <= 1'b1;
                            o_err     <= ERR_OK;
                        end else begin
                            state_reg <= S_WAIT;
                            cnt_reg   <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    // A response on the final allowed cycle still beats the timeout.
                    if (i_res_valid) begin
                        state_reg <= S_DONE;
                        o_done    <= 1'b1;
                        o_err     <= ERR_OK;
                        o_rdata   <= load_ext;
                    end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                        state_reg <= S_DONE;
                        o_done    <= 1'b1;
                        o_err     <= ERR_TMO;
                        o_rdata   <= 32'h0000_0000;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    o_done    <= 1'b0;
                    o_err     <= ERR_OK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_seq.sv
// Bench for dmem_seq: directed cases plus randomized accesses checked against an
// arithmetic reference model of the access rules and cycle timing.
module tb_dmem_seq;

    localparam int TIMEOUT = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_rdata;
    logic [1:0]  o_err;
    logic        o_req;
    logic [31:0] o_req_addr;
    logic        o_req_wen;
    logic [3:0]  o_req_mask;
    logic [31:0] o_req_wdata;
    logic        i_req_ready;
    logic        i_res_valid;
    logic [31:0] i_res_rdata;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] model_rdata = 32'h0;

    always #5 i_clk = ~i_clk;

    dmem_seq #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_mem_read  (i_mem_read),
        .i_mem_write (i_mem_write),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_err       (o_err),
        .o_req       (o_req),
        .o_req_addr  (o_req_addr),
        .o_req_wen   (o_req_wen),
        .o_req_mask  (o_req_mask),
        .o_req_wdata (o_req_wdata),
        .i_req_ready (i_req_ready),
        .i_res_valid (i_res_valid),
        .i_res_rdata (i_res_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall"}, 32'(o_stall), 32'h0);
        chk({tag, ".done"},  32'(o_done),  32'h0);
        chk({tag, ".rdata"}, o_rdata,      32'h0);
        chk({tag, ".err"},   32'(o_err),   32'h0);
        chk({tag, ".req"},   32'(o_req),   32'h0);
        chk({tag, ".addr"},  o_req_addr,   32'h0);
        chk({tag, ".wen"},   32'(o_req_wen), 32'h0);
        chk({tag, ".mask"},  32'(o_req_mask), 32'h0);
        chk({tag, ".wdata"}, o_req_wdata,  32'h0);
    endtask

    // Access size in bytes for a funct3 code.
    function automatic int acc_size(input logic [2:0] f3);
        return 1 << (int'(f3) % 4);
    endfunction

    function automatic int ref_err(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a);
        int sz;
        if (rd && wr) return 2;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2;
        if (wr && f3 >= 3'd4) return 2;
        sz = acc_size(f3);
        if ((a % sz) != 0) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] ref_mask(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        int ofs;
        sz  = acc_size(f3);
        ofs = int'(a % 4) - int'(a % 4) % sz;
        return 32'(((1 << sz) - 1) << ofs);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (acc_size(f3))
            1:       return (wd % 256) * 32'h0101_0101;
            2:       return (wd % 65536) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        longint b;
        longint h;
        b = (longint'(w) >> (8 * (a % 4))) & 255;
        h = (longint'(w) >> (16 * ((a % 4) / 2))) & 65535;
        case (f3)
            3'd0:    return 32'(b >= 128 ? b - 256 : b);
            3'd1:    return 32'(h >= 32768 ? h - 65536 : h);
            3'd2:    return w;
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return 32'h0;
        endcase
    endfunction

    // One access from acceptance to two idle cycles after completion. rdly = cycles
    // ready is held low in REQ; rsp = WAIT cycle index of the response (-1 = never).
    task automatic run_op(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] resp, input int rdly, input int rsp);
        int          err;
        int          done_n;
        int          wait_n;
        bit          issue;
        logic [31:0] exp_rd;
        err    = ref_err(rd, wr, f3, a);
        issue  = (err == 0);
        wait_n = 2 + rdly;
        if (!issue) begin
            done_n = 1;
        end else if (wr) begin
            done_n = 2 + rdly;
        end else if (rsp < 0 || rsp >= TIMEOUT) begin
            done_n = wait_n + TIMEOUT;
            err    = 3;
        end else begin
            done_n = wait_n + rsp + 1;
        end
        if (err != 0)      exp_rd = 32'h0;
        else if (rd)       exp_rd = ref_load(f3, a, resp);
        else               exp_rd = model_rdata;

        for (int n = 0; n <= done_n + 2; n++) begin
            @(negedge i_clk);
            if (n == 0) begin
                i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr;
                i_funct3 = f3; i_addr = a; i_wdata = wd;
            end else begin
                i_valid = 1'b0; i_mem_read = $urandom_range(0, 1); i_mem_write = $urandom_range(0, 1);
                i_funct3 = 3'($urandom_range(0, 7)); i_addr = $urandom; i_wdata = $urandom;
            end
            i_req_ready = (n >= 1 + rdly);
            if (issue && rd && !wr && rsp >= 0 && n == wait_n + rsp) begin
                i_res_valid = 1'b1; i_res_rdata = resp;
            end else if (n < wait_n || n >= done_n) begin
                i_res_valid = 1'($urandom_range(0, 1)); i_res_rdata = $urandom;
            end else begin
                i_res_valid = 1'b0; i_res_rdata = $urandom;
            end
            #1;
            chk($sformatf("%s.stall@%0d", tag, n), 32'(o_stall), 32'(n < done_n));
            chk($sformatf("%s.done@%0d", tag, n),  32'(o_done),  32'(n == done_n));
            if (issue && n >= 1 && n <= 1 + rdly) begin
                chk($sformatf("%s.req@%0d", tag, n),   32'(o_req), 32'h1);
                chk($sformatf("%s.raddr@%0d", tag, n), o_req_addr, a - (a % 4));
                chk($sformatf("%s.mask@%0d", tag, n),  32'(o_req_mask), ref_mask(f3, a));
                chk($sformatf("%s.wen@%0d", tag, n),   32'(o_req_wen), 32'(wr));
                if (wr) chk($sformatf("%s.wdat@%0d", tag, n), o_req_wdata, ref_wdata(f3, wd));
            end else begin
                chk($sformatf("%s.req@%0d", tag, n), 32'(o_req), 32'h0);
            end
            if (n == done_n) begin
                chk($sformatf("%s.err", tag),   32'(o_err), 32'(err));
                chk($sformatf("%s.rdata", tag), o_rdata, exp_rd);
            end else if (n > done_n) begin
                chk($sformatf("%s.hold@%0d", tag, n), o_rdata, exp_rd);
            end
        end
        i_res_valid = 1'b0;
        i_req_ready = 1'b0;
        model_rdata = exp_rd;
        $display("op %-8s rd=%0d wr=%0d f3=%0d addr=%08h -> err=%0d rdata=%08h done@T+%0d",
                 tag, rd, wr, f3, a, err, exp_rd, done_n);
    endtask

    initial begin
        int          done_cnt;
        logic        rd;
        logic        wr;
        int          k;

        i_rst = 1'b0; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        i_funct3 = 3'd0; i_addr = 32'h0; i_wdata = 32'h0;
        i_req_ready = 1'b0; i_res_valid = 1'b0; i_res_rdata = 32'h0;

        // Power-on reset with a start condition present: outputs must still be zero.
        #1 i_rst = 1'b1; i_valid = 1'b1; i_mem_read = 1'b1; i_res_valid = 1'b1;
        #2 chk_all_zero("por");
        repeat (2) @(negedge i_clk);
        i_valid = 1'b0; i_mem_read = 1'b0; i_res_valid = 1'b0;
        i_rst = 1'b0;
        $display("reset released");

        // Directed accesses.
        run_op("lb",     1, 0, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_1234, 0, 0);
        run_op("sh",     0, 1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,         3, -1);
        run_op("lw_mis", 1, 0, 3'b010, 32'h0000_0001, 32'h0,         32'h0,         0, 0);
        run_op("sbu",    0, 1, 3'b100, 32'h0000_0010, 32'h1234_5678, 32'h0,         0, 0);
        run_op("lb_hu",  1, 0, 3'b101, 32'h0000_3002, 32'h0,         32'hF00D_8001, 1, 2);
        run_op("lhu_to", 1, 0, 3'b101, 32'h0000_4002, 32'h0,         32'hCAFE_F00D, 0, TIMEOUT + 1);
        run_op("lh_edge",1, 0, 3'b001, 32'h0000_5000, 32'h0,         32'h0000_9ABC, 0, TIMEOUT - 1);
        run_op("sw",     0, 1, 3'b010, 32'h0000_6004, 32'h0BAD_F00D, 32'h0,         0, 0);
        run_op("rdwr",   1, 1, 3'b010, 32'h0000_7000, 32'h0,         32'h0,         0, 0);

        // Reset while a load is waiting for its response; a late response is ignored.
        @(negedge i_clk);
        i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0;
        i_funct3 = 3'b010; i_addr = 32'h0000_0020; i_req_ready = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_req_ready = 1'b0;
        #1 chk("rst_wait.stall", 32'(o_stall), 32'h1);
        #2 i_rst = 1'b1;
        #1 chk_all_zero("rst_wait");
        i_res_valid = 1'b1; i_res_rdata = 32'hFFFF_FFFF;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        #1;
        chk("rst_late.done",  32'(o_done),  32'h0);
        chk("rst_late.stall", 32'(o_stall), 32'h0);
        chk("rst_late.rdata", o_rdata,      32'h0);
        i_res_valid = 1'b0;
        model_rdata = 32'h0;
        $display("reset during WAIT applied and released");
        run_op("lw_8",   1, 0, 3'b010, 32'h0000_0008, 32'h0,         32'h1234_5678, 0, 0);

        // Back-to-back loads with i_valid held high across the first completion.
        done_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge i_clk);
            if (n == 0) begin
                i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_funct3 = 3'b010;
                i_addr = 32'h0000_0100; i_req_ready = 1'b1;
                i_res_valid = 1'b1; i_res_rdata = 32'hAAAA_5555;
            end
            if (n == 3) begin
                i_addr = 32'h0000_0104; i_res_rdata = 32'h5555_AAAA;
            end
            if (n == 7) i_valid = 1'b0;
            #1;
            if (o_done) done_cnt++;
            chk($sformatf("b2b.req@%0d", n),  32'(o_req),  32'(n == 1 || n == 5));
            chk($sformatf("b2b.done@%0d", n), 32'(o_done), 32'(n == 3 || n == 7));
            if (n == 1) chk("b2b.addr1", o_req_addr, 32'h0000_0100);
            if (n == 5) chk("b2b.addr2", o_req_addr, 32'h0000_0104);
            if (n == 3) chk("b2b.rdata1", o_rdata, 32'hAAAA_5555);
            if (n == 7) chk("b2b.rdata2", o_rdata, 32'h5555_AAAA);
        end
        chk("b2b.done_count", 32'(done_cnt), 32'd2);
        i_res_valid = 1'b0; i_req_ready = 1'b0; i_mem_read = 1'b0;
        model_rdata = 32'h5555_AAAA;
        $display("back-to-back loads: %0d completions", done_cnt);

        // Randomized accesses.
        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 9);
            rd = (k < 5);
            wr = (k == 0) || (k >= 5);
            run_op($sformatf("rnd%0d", i), rd, wr, 3'($urandom_range(0, 7)), $urandom,
                   $urandom, $urandom, $urandom_range(0, 3), int'($urandom_range(0, 6)) - 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dmem_seq.md
Name: dmem_seq

Overview:
- Multi-cycle sequencer between the hart's execute stage and a handshaked data-memory port.
- Accepts one load/store at a time, using the decoder's mem_read/mem_write and the instruction's funct3.
- Generates a word-aligned request with byte mask and lane-replicated write data, then stalls the hart until the access completes.
- Returns sign/zero-extended load data, plus error flags for misalignment, illegal width and bus timeout.

Parameters:
TIMEOUT, 255, max cycles spent in WAIT (response phase) before aborting with bus error; must be ≥1.

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous, active-high reset
i_valid  input  1  execute stage holds an instruction; sampled in IDLE only
i_mem_read  input  1  load (from ctl decoder)
i_mem_write  input  1  store (from ctl decoder)
i_funct3  input  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_addr  input  32  effective byte address (ALU result)
i_wdata  input  32  rs2 store data
o_stall  output  1  freeze PC/pipeline; combinational
o_done  output  1  one-cycle completion pulse
o_rdata  output  32  extended load data, valid while o_done
o_err  output  2  valid with o_done: 00 ok, 01 misaligned, 10 illegal width/op, 11 bus timeout
o_req  output  1  memory request valid
o_req_addr  output  32  {i_addr[31:2],2'b00}, latched
o_req_wen  output  1  1 = write
o_req_mask  output  4  byte enables
o_req_wdata  output  32  lane-replicated store data
i_req_ready  input  1  memory accepts request this cycle
i_res_valid  input  1  read response valid
i_res_rdata  input  32  read response word

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0: o_req, o_done, o_stall, o_err, o_rdata, o_req_addr, o_req_mask, o_req_wdata, o_req_wen. Timeout counter 0.
- States: IDLE, REQ, WAIT, DONE.
- Start condition in IDLE: start = i_valid & (i_mem_read | i_mem_write).
  - No start: stay in IDLE.
  - On start, latch addr, funct3, op, mask and wdata, then check:
  - both read and write set, or funct3 not in {000,001,010,100,101}, or funct3 ∈ {100,101} on a store: go DONE with o_err=10, no request issued.
  - misaligned (H with addr[0]=1; W with addr[1:0]≠0): go DONE with o_err=01, no request issued.
  - otherwise: go REQ.
- REQ: o_req=1 and request fields held stable until handshake.
  - Handshake = o_req & i_req_ready.
  - Write handshake: go DONE.
  - Read handshake: go WAIT, counter cleared.
  - No handshake: stay in REQ. No timeout applies in REQ.
- WAIT: o_req=0; counter increments each cycle.
  - i_res_valid: extend i_res_rdata into o_rdata, go DONE.
  - Counter reaches TIMEOUT with no response: go DONE with o_err=11.
  - i_res_valid on the same cycle as the limit: response wins.
- DONE: o_done=1 for exactly one cycle, then go IDLE. A new op is accepted only on the following IDLE cycle.
- o_stall = start in IDLE | state ∈ {REQ, WAIT}. It is 0 in DONE, so the hart advances on the o_done cycle.
- Mask and write data:
  - B: mask = 1<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - H: mask = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - W: mask = 1111; wdata unchanged.
  - Reads also drive the mask (informational).
- Load extension:
  - Select byte lane addr[1:0], or half lane addr[1].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- o_rdata holds its value until the next load completes. It is 0 on any error.
- i_res_valid outside WAIT is ignored, including a stale response after reset.
- Latency with zero-wait memory:
  - Load: accept T, REQ T+1, WAIT T+2 (response), DONE T+3.
  - Store: DONE at T+2.
  - Error: DONE at T+1.

Test Plan:
- LB: addr=0x1003, i_res_rdata=0x80FF_1234, ready/valid immediate → o_req_addr=0x1000, mask=1000, o_rdata=0xFFFF_FF80, o_done at T+3, o_stall high T..T+2.
- SH: addr=0x2002, wdata=0xDEAD_BEEF, i_req_ready held low 3 cycles → o_req stays high with mask=1100 and wdata=0xBEEF_BEEF stable; o_done 1 cycle after ready.
- LW at addr=0x0001 → no o_req, o_err=01 at T+1. Store with funct3=100 → o_err=10.
- LHU: addr=0x4002, i_res_valid never arrives, TIMEOUT=4 → o_done with o_err=11 and o_rdata=0; i_res_valid next cycle ignored.
- Assert i_rst during WAIT → all outputs 0 immediately; a late i_res_valid is ignored. Next LW addr=0x8, data 0x1234_5678 → o_rdata=0x1234_5678.
- Back-to-back: two loads with i_valid held high → second request issued only after DONE→IDLE, and exactly 2 o_done pulses.
